// File: rtl/vx_commit_arbiter.sv
// Writeback commit arbiter: merges the execute-unit commit ports into one registered
// writeback stream using round-robin grants, keeping multi-beat packets contiguous.
module vx_commit_arbiter #(
   parameter int NUM_SRC     = 5,
   parameter int NUM_THREADS = 4,
   parameter int NUM_WARPS   = 4,
   parameter int UUID_BITS   = 44,
   parameter int NR_BITS     = 6,
   parameter int XLEN        = 32,
   localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int SRC_BITS   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_SRC-1:0]                  commit_valid,
   output logic [NUM_SRC-1:0]                  commit_ready,
   input  logic [NUM_SRC*UUID_BITS-1:0]        commit_uuid,
   input  logic [NUM_SRC*NW_BITS-1:0]          commit_wid,
   input  logic [NUM_SRC*XLEN-1:0]             commit_PC,
   input  logic [NUM_SRC*NUM_THREADS-1:0]      commit_tmask,
   input  logic [NUM_SRC-1:0]                  commit_wb,
   input  logic [NUM_SRC*NR_BITS-1:0]          commit_rd,
   input  logic [NUM_SRC*NUM_THREADS*XLEN-1:0] commit_data,
   input  logic [NUM_SRC-1:0]                  commit_eop,
   output logic                                wb_valid,
   output logic [UUID_BITS-1:0]                wb_uuid,
   output logic [NW_BITS-1:0]                  wb_wid,
   output logic [XLEN-1:0]                     wb_PC,
   output logic [NUM_THREADS-1:0]              wb_tmask,
   output logic [NR_BITS-1:0]                  wb_rd,
   output logic [NUM_THREADS*XLEN-1:0]         wb_data,
   output logic                                wb_eop,
   output logic [31:0]                         wb_count,
   output logic [31:0]                         retire_count
);

   // Handshake: a beat moves when commit_valid[i] & commit_ready[i] in the same cycle.
   // commit_ready is a combinational one-hot function of commit_valid, so sources must
   // hold valid and fields stable without waiting on ready.

   typedef enum logic {S_OPEN, S_LOCKED} state_t;

   state_t                      state_q, state_d;
   logic [SRC_BITS-1:0]         lock_src_q, lock_src_d;
   logic [SRC_BITS-1:0]         last_grant_q;
   logic                        grant_found;
   logic [SRC_BITS-1:0]         grant_idx;
   logic                        fire;

   logic [UUID_BITS-1:0]        sel_uuid;
   logic [NW_BITS-1:0]          sel_wid;
   logic [XLEN-1:0]             sel_pc;
   logic [NUM_THREADS-1:0]      sel_tmask;
   logic [NR_BITS-1:0]          sel_rd;
   logic [NUM_THREADS*XLEN-1:0] sel_data;
   logic                        sel_wb;
   logic                        sel_eop;

   always_comb begin
      int idx;
      state_d      = state_q;
      lock_src_d   = lock_src_q;
      grant_found  = 1'b0;
      grant_idx    = '0;
      idx          = 0;
      commit_ready = '0;

      if (state_q == S_LOCKED) begin
         // A stalled locked source blocks everyone until its packet completes.
         if (commit_valid[lock_src_q]) begin
            grant_found = 1'b1;
            grant_idx   = lock_src_q;
         end
      end else begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_SRC;
            if (!grant_found && commit_valid[idx]) begin
               grant_found = 1'b1;
               grant_idx   = SRC_BITS'(idx);
            end
         end
      end

      fire = grant_found && !reset;
      if (fire) begin
         commit_ready[grant_idx] = 1'b1;
         if (commit_eop[grant_idx]) begin
            state_d = S_OPEN;
         end else begin
            state_d    = S_LOCKED;
            lock_src_d = grant_idx;
         end
      end
   end

   always_comb begin
      sel_uuid  = '0;
      sel_wid   = '0;
      sel_pc    = '0;
      sel_tmask = '0;
      sel_rd    = '0;
      sel_data  = '0;
      sel_wb    = 1'b0;
      sel_eop   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_idx == SRC_BITS'(i)) begin
            sel_uuid  = commit_uuid[i*UUID_BITS +: UUID_BITS];
            sel_wid   = commit_wid[i*NW_BITS +: NW_BITS];
            sel_pc    = commit_PC[i*XLEN +: XLEN];
            sel_tmask = commit_tmask[i*NUM_THREADS +: NUM_THREADS];
            sel_rd    = commit_rd[i*NR_BITS +: NR_BITS];
            sel_data  = commit_data[i*NUM_THREADS*XLEN +: NUM_THREADS*XLEN];
            sel_wb    = commit_wb[i];
            sel_eop   = commit_eop[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_OPEN;
         lock_src_q   <= '0;
         last_grant_q <= SRC_BITS'(NUM_SRC - 1);
         wb_valid     <= 1'b0;
         wb_uuid      <= '0;
         wb_wid       <= '0;
         wb_PC        <= '0;
         wb_tmask     <= '0;
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_eop       <= 1'b0;
         wb_count     <= '0;
         retire_count <= '0;
      end else begin
         state_q    <= state_d;
         lock_src_q <= lock_src_d;
         wb_valid   <= fire && sel_wb;
         if (fire) begin
            last_grant_q <= grant_idx;
         end
         // Non-writing beats leave the output fields untouched.
         if (fire && sel_wb) begin
            wb_uuid  <= sel_uuid;
            wb_wid   <= sel_wid;
            wb_PC    <= sel_pc;
            wb_tmask <= sel_tmask;
            wb_rd    <= sel_rd;
            wb_data  <= sel_data;
            wb_eop   <= sel_eop;
            wb_count <= wb_count + 32'd1;
         end
         if (fire && sel_eop) begin
            retire_count <= retire_count + 32'd1;
         end
      end
   end

endmodule
